i2s_rx: RTL and testbench

- I2S receive path: deserialises ADC serial data (ac_adc_sdata) into 24-bit left/right sample pairs. Runs as a slave on the BCLK/LRCLK pair driven by i2s_ctrl.
- Sits beside i2s_ctrl in the nexysVideo top. Feeds captured audio to downstream DSP/mixer logic (in_audioL/in_audioR) through a valid/ready handshake.
- BCLK/LRCLK/SDATA are oversampled in the clk_12 (12.288 MHz) domain. BCLK must be at most clk_i/4.

---
 rtl/i2s_pkg.sv | 19 +
 rtl/i2s_rx_if.sv | 40 ++++
 rtl/i2s_sync_edge.sv | 32 +++
 rtl/i2s_rx.sv | 158 +++++++++++++++
 tb/tb_i2s_rx.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S receive path.
// FSM states, channel select and synchroniser depth.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SHIFT,
        PAD
    } state_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_rx_if.sv
// Sample-pair handshake bundle between i2s_rx and its consumer.
// frame_err_o exists only when I2S_RX_FRAME_ERR_EN is defined.
interface i2s_rx_if #(
    parameter int width_p = 24
);
    logic [width_p-1:0] left_o;
    logic [width_p-1:0] right_o;
    logic               valid_o;
    logic               ready_i;
    logic               overflow_o;
    logic               clr_ovf_i;
`ifdef I2S_RX_FRAME_ERR_EN
    logic               frame_err_o;
`endif

    modport master (
        input  ready_i,
        input  clr_ovf_i,
`ifdef I2S_RX_FRAME_ERR_EN
        output frame_err_o,
`endif
        output left_o,
        output right_o,
        output valid_o,
        output overflow_o
    );

    modport slave (
        output ready_i,
        output clr_ovf_i,
`ifdef I2S_RX_FRAME_ERR_EN
        input  frame_err_o,
`endif
        input  left_o,
        input  right_o,
        input  valid_o,
        input  overflow_o
    );

endinterface

// File: rtl/i2s_sync_edge.sv
// Synchroniser for an edge source plus companion data bits.
// All bits share one depth so they stay aligned; rise_o strobes edge rises.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         edge_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         rise_o
);

    logic [SYNC_STAGES-1:0][W:0] stg;
    logic                        prev;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stg  <= '0;
            prev <= 1'b0;
        end else begin
            stg  <= {stg[SYNC_STAGES-2:0], {d_i, edge_i}};
            prev <= stg[SYNC_STAGES-1][0];
        end
    end

    assign q_o    = stg[SYNC_STAGES-1][W:1];
    assign rise_o = stg[SYNC_STAGES-1][0] & ~prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: 24-bit left/right pairs over a valid/ready bus.
// I2S_RX_FRAME_ERR_EN: short words flag frame_err_o and realign.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int width_p     = 24,
    parameter int slot_bits_p = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      bclk_i,
    input  logic      lrclk_i,
    input  logic      sdata_i,
    input  logic      en_i,
    i2s_rx_if.master  bus
);

    localparam int CW = $clog2(slot_bits_p + 1);

    logic [1:0]         sync_q;
    logic               strobe;
    logic               lr_s;
    logic               sd_s;

    state_t             state;
    chan_t              ch;
    logic               lr_prev;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_inc;
    logic [width_p-1:0] shreg;
    logic [width_p-1:0] stage_l;
    logic [width_p-1:0] full_w;
    logic [width_p-1:0] word;
    logic               lr_chg;
    logic               lat;
    logic               pair_done;
    logic               accept;
    logic               load;
    logic               ovf_set;
`ifdef I2S_RX_FRAME_ERR_EN
    logic               fe_set;
`else
    logic [width_p-1:0] short_w;
`endif

    i2s_sync_edge #(.W(2)) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .edge_i (bclk_i),
        .d_i    ({sdata_i, lrclk_i}),
        .q_o    (sync_q),
        .rise_o (strobe)
    );

    assign lr_s    = sync_q[0];
    assign sd_s    = sync_q[1];
    assign lr_chg  = lr_s != lr_prev;
    assign full_w  = {shreg[width_p-2:0], sd_s};
    assign cnt_inc = (cnt == CW'(slot_bits_p)) ? cnt : cnt + CW'(1);
`ifndef I2S_RX_FRAME_ERR_EN
    // missing LSBs of a short word come in as zeros
    assign short_w = shreg << (CW'(width_p) - cnt);
`endif

    always_comb begin
        lat  = 1'b0;
        word = full_w;
`ifdef I2S_RX_FRAME_ERR_EN
        fe_set = 1'b0;
`endif
        if (strobe && en_i && state == SHIFT) begin
            if (lr_chg) begin
`ifdef I2S_RX_FRAME_ERR_EN
                fe_set = 1'b1;
`else
                lat  = 1'b1;
                word = short_w;
`endif
            end else if (cnt == CW'(width_p - 1)) begin
                lat = 1'b1;
            end
        end
    end

    assign pair_done = lat && ch == CH_RIGHT;
    assign accept    = bus.valid_o && bus.ready_i;
    assign load      = pair_done && (!bus.valid_o || bus.ready_i);
    assign ovf_set   = pair_done && bus.valid_o && !bus.ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            ch             <= CH_LEFT;
            lr_prev        <= 1'b0;
            cnt            <= '0;
            shreg          <= '0;
            stage_l        <= '0;
            bus.left_o     <= '0;
            bus.right_o    <= '0;
            bus.valid_o    <= 1'b0;
            bus.overflow_o <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
            bus.frame_err_o <= 1'b0;
`endif
        end else begin
            if (strobe) lr_prev <= lr_s;
            if (!en_i) begin
                state <= IDLE;
            end else if (strobe) begin
                unique case (state)
                    IDLE: if (lr_prev && !lr_s) begin
                        state <= DELAY;
                        ch    <= CH_LEFT;
                        cnt   <= '0;
                    end
                    DELAY: begin
                        shreg <= full_w;
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                    SHIFT: if (lr_chg) begin
`ifdef I2S_RX_FRAME_ERR_EN
                        state <= IDLE;
`else
                        state <= DELAY;
                        ch    <= chan_t'(lr_s);
                        cnt   <= '0;
`endif
                    end else begin
                        shreg <= full_w;
                        cnt   <= cnt_inc;
                        if (lat) state <= PAD;
                    end
                    PAD: if (lr_chg) begin
                        state <= DELAY;
                        ch    <= chan_t'(lr_s);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                endcase
            end
            if (lat && ch == CH_LEFT) stage_l <= word;
            if (load) begin
                bus.left_o  <= stage_l;
                bus.right_o <= word;
                bus.valid_o <= 1'b1;
            end else if (accept) begin
                bus.valid_o <= 1'b0;
            end
            bus.overflow_o <= ovf_set | (bus.overflow_o & ~bus.clr_ovf_i);
`ifdef I2S_RX_FRAME_ERR_EN
            bus.frame_err_o <= fe_set | (bus.frame_err_o & ~bus.clr_ovf_i);
`endif
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: a behavioural I2S master drives random frames and
// accepted pairs are compared with the words each frame was built from.
module tb_i2s_rx;

    localparam int W = 24;

    logic clk_i = 1'b0;
    logic rst_i;
    logic bclk_i;
    logic lrclk_i;
    logic sdata_i;
    logic en_i;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] acc_q[$];
    logic [2*W-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    i2s_rx_if #(.width_p(W)) bus ();

    i2s_rx #(.width_p(W), .slot_bits_p(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bclk_i  (bclk_i),
        .lrclk_i (lrclk_i),
        .sdata_i (sdata_i),
        .en_i    (en_i),
        .bus     (bus)
    );

    always @(negedge clk_i)
        if (rst_i && bus.valid_o && bus.ready_i)
            acc_q.push_back({bus.left_o, bus.right_o});

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // one BCLK period, BCLK = clk/4; lr/data change on the falling edge
    task automatic bit_cyc(input logic lr, input logic d);
        bclk_i  = 1'b0;
        lrclk_i = lr;
        sdata_i = d;
        tick();
        tick();
        bclk_i = 1'b1;
        tick();
        tick();
    endtask

    // slot 0 is the I2S delay slot, slots 1..nb carry the word MSB first
    task automatic send_half(input logic lr, input logic [W-1:0] w,
                             input int nb, input int len, input int en_off);
        logic d;
        for (int k = 0; k < len; k++) begin
            if (k == en_off) en_i = 1'b0;
            if (en_off >= 0 && k == en_off + 3) en_i = 1'b1;
            if (k >= 1 && k <= nb) d = w[W-k];
            else d = 1'($urandom);
            bit_cyc(lr, d);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              input int ll, input int rl);
        send_half(1'b0, l, W, ll, -1);
        send_half(1'b1, r, W, rl, -1);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        en_i = 1'b0;
        bclk_i = 1'b0;
        lrclk_i = 1'b1;
        sdata_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.clr_ovf_i = 1'b0;
        repeat (3) tick();
        total++;
        if (bus.left_o !== '0) begin
            bad++;
            $display("FAIL reset_left got=%h want=0", bus.left_o);
        end
        total++;
        if (bus.right_o !== '0) begin
            bad++;
            $display("FAIL reset_right got=%h want=0", bus.right_o);
        end
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", bus.valid_o);
        end
        total++;
        if (bus.overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf got=%b want=0", bus.overflow_o);
        end
`ifdef I2S_RX_FRAME_ERR_EN
        total++;
        if (bus.frame_err_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ferr got=%b want=0", bus.frame_err_o);
        end
`endif
        rst_i = 1'b1;
        en_i = 1'b1;
        tick();
        send_half(1'b1, '0, 0, 4, -1);
    endtask

    task automatic test_frame();
        logic [W-1:0] l = 24'hA5_5A_01;
        logic [W-1:0] r = 24'h80_00_FF;
        acc_q.delete();
        send_half(1'b0, l, W, 32, -1);
        for (int k = 0; k < W; k++)
            bit_cyc(1'b1, (k == 0) ? 1'($urandom) : r[W-k]);
        bclk_i = 1'b0;
        sdata_i = r[0];
        tick();
        tick();
        bclk_i = 1'b1;
        tick();
        tick();
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL lat_early got=%b want=0", bus.valid_o);
        end
        tick();
        total++;
        if (bus.valid_o !== 1'b1) begin
            bad++;
            $display("FAIL lat_valid got=%b want=1", bus.valid_o);
        end
        total++;
        if (bus.left_o !== l || bus.right_o !== r) begin
            bad++;
            $display("FAIL frame_data got=%h/%h want=%h/%h",
                     bus.left_o, bus.right_o, l, r);
        end
        tick();
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL frame_vfall got=%b want=0", bus.valid_o);
        end
        for (int k = W + 1; k < 32; k++) bit_cyc(1'b1, 1'($urandom));
        total++;
        if (acc_q.size() != 1) begin
            bad++;
            $display("FAIL frame_count got=%0d want=1", acc_q.size());
        end
    endtask

    task automatic test_random();
        logic [W-1:0] l;
        logic [W-1:0] r;
        acc_q.delete();
        exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            l = W'($urandom);
            r = W'($urandom);
            exp_q.push_back({l, r});
            send_frame(l, r, $urandom_range(32, 25), $urandom_range(32, 25));
        end
        total++;
        if (acc_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count got=%0d want=%0d",
                     acc_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            total++;
            if (acc_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_pair%0d got=%h want=%h",
                         i, acc_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_short();
        logic [W-1:0] r = W'($urandom);
        logic [W-1:0] nl = W'($urandom);
        logic [W-1:0] nr = W'($urandom);
        logic [W-1:0] ones = 24'hFFFFF0;
        acc_q.delete();
        exp_q.delete();
`ifndef I2S_RX_FRAME_ERR_EN
        exp_q.push_back({24'hFFFFF0, r});
`endif
        exp_q.push_back({nl, nr});
        send_half(1'b0, ones, 20, 21, -1);
        send_half(1'b1, r, W, 32, -1);
        send_frame(nl, nr, 32, 32);
        total++;
        if (acc_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL short_count got=%0d want=%0d",
                     acc_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            total++;
            if (acc_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL short_pair%0d got=%h want=%h",
                         i, acc_q[i], exp_q[i]);
            end
        end
`ifdef I2S_RX_FRAME_ERR_EN
        total++;
        if (bus.frame_err_o !== 1'b1) begin
            bad++;
            $display("FAIL short_ferr got=%b want=1", bus.frame_err_o);
        end
        bus.clr_ovf_i = 1'b1;
        tick();
        bus.clr_ovf_i = 1'b0;
        total++;
        if (bus.frame_err_o !== 1'b0) begin
            bad++;
            $display("FAIL short_fclr got=%b want=0", bus.frame_err_o);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [W-1:0] al = W'($urandom);
        logic [W-1:0] ar = W'($urandom);
        bus.ready_i = 1'b0;
        send_frame(al, ar, 32, 32);
        total++;
        if (bus.valid_o !== 1'b1 || bus.left_o !== al || bus.right_o !== ar) begin
            bad++;
            $display("FAIL bp_first got=%b %h/%h want=1 %h/%h",
                     bus.valid_o, bus.left_o, bus.right_o, al, ar);
        end
        send_frame(W'($urandom), W'($urandom), 32, 32);
        total++;
        if (bus.valid_o !== 1'b1 || bus.left_o !== al || bus.right_o !== ar) begin
            bad++;
            $display("FAIL bp_hold got=%b %h/%h want=1 %h/%h",
                     bus.valid_o, bus.left_o, bus.right_o, al, ar);
        end
        total++;
        if (bus.overflow_o !== 1'b1) begin
            bad++;
            $display("FAIL bp_ovf got=%b want=1", bus.overflow_o);
        end
        bus.clr_ovf_i = 1'b1;
        tick();
        bus.clr_ovf_i = 1'b0;
        total++;
        if (bus.overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_clr got=%b want=0", bus.overflow_o);
        end
        acc_q.delete();
        bus.ready_i = 1'b1;
        tick();
        tick();
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== {al, ar}) begin
            bad++;
            $display("FAIL bp_accept got=%0d pairs want=1 pair %h",
                     acc_q.size(), {al, ar});
        end
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_vfall got=%b want=0", bus.valid_o);
        end
    endtask

    task automatic test_en_toggle();
        logic [W-1:0] yl = W'($urandom);
        logic [W-1:0] yr = W'($urandom);
        acc_q.delete();
        send_half(1'b0, W'($urandom), W, 32, 8);
        send_half(1'b1, W'($urandom), W, 32, -1);
        send_frame(yl, yr, 32, 32);
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== {yl, yr}) begin
            bad++;
            $display("FAIL en_resume got=%0d pairs want=1 pair %h",
                     acc_q.size(), {yl, yr});
        end
    endtask

    task automatic test_align();
        logic [W-1:0] fl = W'($urandom);
        logic [W-1:0] fr = W'($urandom);
        acc_q.delete();
        en_i = 1'b0;
        send_half(1'b0, W'($urandom), W, 12, -1);
        en_i = 1'b1;
        send_half(1'b0, W'($urandom), W, 8, -1);
        send_half(1'b1, W'($urandom), W, 32, -1);
        send_frame(fl, fr, 32, 32);
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== {fl, fr}) begin
            bad++;
            $display("FAIL align got=%0d pairs want=1 pair %h",
                     acc_q.size(), {fl, fr});
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] ql = W'($urandom);
        logic [W-1:0] qr = W'($urandom);
        bus.ready_i = 1'b0;
        send_frame(W'($urandom), W'($urandom), 32, 32);
        send_frame(W'($urandom), W'($urandom), 32, 32);
        send_half(1'b0, W'($urandom), W, 10, -1);
        rst_i = 1'b0;
        #2;
        total++;
        if (bus.valid_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL rmid_flags got=%b%b want=00",
                     bus.valid_o, bus.overflow_o);
        end
        total++;
        if (bus.left_o !== '0 || bus.right_o !== '0) begin
            bad++;
            $display("FAIL rmid_data got=%h/%h want=0/0",
                     bus.left_o, bus.right_o);
        end
        tick();
        rst_i = 1'b1;
        bus.ready_i = 1'b1;
        acc_q.delete();
        send_half(1'b0, W'($urandom), W, 22, -1);
        send_half(1'b1, W'($urandom), W, 32, -1);
        send_frame(ql, qr, 32, 32);
        total++;
        if (acc_q.size() != 1 || acc_q[0] !== {ql, qr}) begin
            bad++;
            $display("FAIL rmid_realign got=%0d pairs want=1 pair %h",
                     acc_q.size(), {ql, qr});
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_random();
        test_short();
        test_backpressure();
        test_en_toggle();
        test_align();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
